// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM geometry constants and arbiter FSM state type
package ram_pkg;
    localparam int RAM_AW = 4;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } ram_arb_state_t;
endpackage

// File: rtl/ram.sv
// rtl/ram.sv - 16x8 synchronous single-port RAM, registered read data
module ram
    import ram_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] indata,
    output logic [DW-1:0] outdata
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] outdata_q;

    always_ff @(posedge clk) begin
        if (rw) begin
            mem_q[addr] <= indata;
        end else begin
            outdata_q <= mem_q[addr];
        end
    end

    assign outdata = outdata_q;
endmodule

// File: rtl/ram_rr_pick.sv
// rtl/ram_rr_pick.sv - 2-way winner select; RAM_ARB_FIXED_PRI_EN selects fixed priority
module ram_rr_pick (
    input  logic req0,
    input  logic req1,
`ifndef RAM_ARB_FIXED_PRI_EN
    input  logic last_grant,
`endif
    output logic grant
);
    // grant: 0 = port 0 wins, 1 = port 1 wins
    always_comb begin
        grant = 1'b0;
`ifdef RAM_ARB_FIXED_PRI_EN
        if (!req0 && req1) begin
            grant = 1'b1;
        end
`else
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
`endif
    end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter/sequencer for the single-port RAM; RAM_ARB_FIXED_PRI_EN selects fixed priority
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    ram_arb_state_t state_q, state_d;
    logic           grant_q, grant_d;
    logic           ram_rw_q, ram_rw_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
    logic           pick;

`ifdef RAM_ARB_FIXED_PRI_EN
    ram_rr_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .grant (pick)
    );
`else
    logic last_q, last_d;

    ram_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .grant      (pick)
    );

    // Reset as "port 1 granted last" so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == DONE) begin
            last_d = grant_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ram_rw_d    = ram_rw_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                ram_rw_d = 1'b0;
                if (req0 || req1) begin
                    grant_d     = pick;
                    ram_rw_d    = pick ? we1 : we0;
                    ram_addr_d  = pick ? addr1 : addr0;
                    ram_wdata_d = pick ? wdata1 : wdata0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Access happens at this closing edge; drop rw so DONE never writes
                ram_rw_d = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                ram_rw_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign ack0      = (state_q == DONE) && !grant_q;
    assign ack1      = (state_q == DONE) && grant_q;
    assign rdata     = ram_rdata;
    assign busy      = (state_q != IDLE);
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter driving a ram instance
module tb_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef RAM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        int            port;
        bit            rd;
        logic [DW-1:0] data;
    } sb_entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy;
    logic [DW-1:0] rdata;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    sb_entry_t     sb[$];
    sb_entry_t     mon_e;
    logic [DW-1:0] model_mem [2**AW];
    int            n_chk  = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    ram #(.AW(AW), .DW(DW)) u_ram (
        .clk     (clk),
        .rw      (ram_rw),
        .addr    (ram_addr),
        .indata  (ram_wdata),
        .outdata (ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard consumer: every ack pops one expected transaction
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            check("ack_excl", {31'b0, ack0 & ack1}, 32'd0);
            if (sb.size() == 0) begin
                check("unexp_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {31'b0, ack1}, mon_e.port);
                if (mon_e.rd) begin
                    check("rdata", {24'b0, rdata}, {24'b0, mon_e.data});
                end
            end
        end
    end

    task automatic push(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb_entry_t e;
        e.port = port;
        e.rd   = !we;
        e.data = model_mem[a];
        sb.push_back(e);
        if (we) model_mem[a] = d;
    endtask

    task automatic drive(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Counts negedges until the port's ack; expired bound shows as a latency failure
    task automatic wait_ack(input int port, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((port == 0) ? ack0 : ack1) && n < 12);
        check("latency", n, exp_n);
    endtask

    task automatic txn(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        push(port, we, a, d);
        drive(port, we, a, d);
        wait_ack(port, 2);
        if (port == 0) req0 = 1'b0; else req1 = 1'b1 & 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst_n = 1'b0;
        #1;
        check("rst_ram_rw", {31'b0, ram_rw}, 0);
        check("rst_ram_addr", {28'b0, ram_addr}, 0);
        check("rst_ram_wdata", {24'b0, ram_wdata}, 0);
        check("rst_ack", {30'b0, ack1, ack0}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Port 0 write then read of the same word
        txn(0, 1'b1, 4'd3, 8'hA5);
        txn(0, 1'b0, 4'd3, 8'h00);

        // Port 1 writes word 15, port 0 reads it on the following grant
        @(negedge clk);
        push(1, 1'b1, 4'd15, 8'h3C);
        drive(1, 1'b1, 4'd15, 8'h3C);
        @(negedge clk);
        push(0, 1'b0, 4'd15, 8'h00);
        drive(0, 1'b0, 4'd15, 8'h00);
        wait_ack(1, 1);
        req1 = 1'b0;
        wait_ack(0, 3);
        req0 = 1'b0;

        // Operands changed after grant are ignored
        txn(0, 1'b1, 4'd9, 8'h99);
        @(negedge clk);
        push(0, 1'b1, 4'd5, 8'h11);
        drive(0, 1'b1, 4'd5, 8'h11);
        @(negedge clk);
        addr0 = 4'd9; wdata0 = 8'h77; we0 = 1'b0;
        wait_ack(0, 1);
        req0 = 1'b0;
        txn(0, 1'b0, 4'd5, 8'h00);
        txn(1, 1'b0, 4'd9, 8'h00);

        // Reset pulsed during ISSUE of a write to word 7
        @(negedge clk);
        drive(0, 1'b1, 4'd7, 8'h5A);
        @(negedge clk);
        check("issue_rw", {31'b0, ram_rw}, 1);
        check("issue_busy", {31'b0, busy}, 1);
        #2;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("mid_rst_rw", {31'b0, ram_rw}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_ack", {30'b0, ack1, ack0}, 0);
        check("mid_rst_addr", {28'b0, ram_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_ack_after_rst", {30'b0, ack1, ack0}, 0);
        txn(0, 1'b1, 4'd7, 8'h5A);
        txn(0, 1'b0, 4'd7, 8'h00);

        // Continuous contention straight out of reset
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b1, 4'd1, 8'h10);
        drive(1, 1'b1, 4'd2, 8'h20);
        for (int k = 0; k < 6; k++) begin
            if (FIXED || (k % 2 == 0)) push(0, 1'b1, 4'd1, 8'h10);
            else push(1, 1'b1, 4'd2, 8'h20);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(ack0 || ack1) && n < 12);
            check("cont_gap", n, (k == 0) ? 2 : 3);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        txn(0, 1'b0, 4'd1, 8'h00);
        if (!FIXED) txn(1, 1'b0, 4'd2, 8'h00);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
